// File: rtl/cal_angle_div_seq.sv
// cal_angle_div_seq: iterative unsigned fixed-point divider for the angle path.
// Computes quo = (dividend << FRAC_W) / divisor with restoring division,
// one quotient bit per clock. The remainder and a divide-by-zero flag are
// also produced. Both ends use a valid/ready handshake, with one operation
// in flight at a time.
module cal_angle_div_seq #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8,
  parameter int FRAC_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DIVIDEND_W-1:0]          dividend,
  input  logic [DIVISOR_W-1:0]           divisor,
  input  logic                           val_i,
  output logic                           rdy_o,
  output logic [DIVIDEND_W+FRAC_W-1:0]   quo,
  output logic [DIVISOR_W-1:0]           rem,
  output logic                           dbz,
  output logic                           val_o,
  input  logic                           rdy_i
);

  localparam int QUO_W = DIVIDEND_W + FRAC_W;
  localparam int CNT_W = $clog2(QUO_W);
  localparam int REM_W = DIVISOR_W + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [QUO_W-1:0]   dvd_sh;    // scaled dividend, consumed MSB first
  logic [DIVISOR_W-1:0] dvs;     // latched divisor
  logic [REM_W-1:0]   prem;      // partial remainder
  logic [QUO_W-1:0]   quo_acc;   // quotient bits collected so far
  logic [CNT_W-1:0]   cnt;       // iteration index, 0 .. QUO_W-1

  logic [REM_W-1:0]   shifted;
  logic [REM_W:0]     trial;
  logic               q_bit;
  logic [REM_W-1:0]   prem_next;
  logic [QUO_W-1:0]   quo_next;
  logic               accept;
  logic               last_iter;

  assign accept    = (state == IDLE) && val_i && rdy_o;
  assign last_iter = (cnt == CNT_W'(QUO_W - 1));

  // One restoring-division step: shift in the next bit and trial-subtract.
  always_comb begin
    // NOTE: every output of this block gets a value on every path, so no latch can be inferred.
    shifted   = {prem[DIVISOR_W-1:0], dvd_sh[QUO_W-1]};
    trial     = {1'b0, shifted} - {2'b00, dvs};
    q_bit     = ~trial[REM_W];
    prem_next = q_bit ? trial[REM_W-1:0] : shifted;
    quo_next  = {quo_acc[QUO_W-2:0], q_bit};
  end

  // Iteration datapath: load on accept, then advance one bit per BUSY cycle.
  always_ff @(posedge clk) begin
    // NOTE: these registers are fully reloaded on every accept and are only
    // observed under control of the reset FSM, so they carry no reset.
    if (accept) begin
      dvd_sh  <= QUO_W'(dividend) << FRAC_W;
      dvs     <= divisor;
      prem    <= '0;
      quo_acc <= '0;
      cnt     <= '0;
    end else if (state == BUSY) begin
      dvd_sh  <= dvd_sh << 1;
      prem    <= prem_next;
      quo_acc <= quo_next;
      cnt     <= cnt + CNT_W'(1);
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
      rdy_o <= 1'b0;
      val_o <= 1'b0;
      quo   <= '0;
      rem   <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rdy_o <= 1'b0;
            if (divisor == '0) begin
              // The result is loaded on the edge entering DONE. val_o
              // follows one edge later, which gives a latency of 1.
              state <= DONE;
              quo   <= '1;
              rem   <= '0;
              dbz   <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end else begin
            rdy_o <= 1'b1;
          end
        end
        BUSY: begin
          if (last_iter) begin
            state <= DONE;
            val_o <= 1'b1;
            quo   <= quo_next;
            rem   <= prem_next[DIVISOR_W-1:0];
            dbz   <= 1'b0;
          end
        end
        DONE: begin
          if (!val_o) begin
            val_o <= 1'b1;
          end else if (rdy_i) begin
            val_o <= 1'b0;
            rdy_o <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cal_angle_div_seq.sv
// Self-checking bench for cal_angle_div_seq. The default instance is driven
// through a scoreboard queue. Expected results are pushed on accept and
// popped when the result handshake completes. A second instance with 12/12/0
// parameters is checked directly against a reference model.
module tb_cal_angle_div_seq;

  typedef struct packed {
    logic [23:0] quo;
    logic [7:0]  rem;
    logic        dbz;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        val_i;
  logic        rdy_o;
  logic [23:0] quo;
  logic [7:0]  rem;
  logic        dbz;
  logic        val_o;
  logic        rdy_i;
  logic        rdy_fix;
  logic        rdy_rand;
  logic        rand_mode;

  logic [11:0] alt_dividend;
  logic [11:0] alt_divisor;
  logic        alt_val_i;
  logic        alt_rdy_o;
  logic [11:0] alt_quo;
  logic [11:0] alt_rem;
  logic        alt_dbz;
  logic        alt_val_o;
  logic        alt_rdy_i;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  vec_t vecs[10];

  assign rdy_i = rand_mode ? rdy_rand : rdy_fix;

  cal_angle_div_seq #(.DIVIDEND_W(16), .DIVISOR_W(8), .FRAC_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .dividend(dividend), .divisor(divisor),
    .val_i(val_i), .rdy_o(rdy_o), .quo(quo), .rem(rem), .dbz(dbz),
    .val_o(val_o), .rdy_i(rdy_i)
  );

  cal_angle_div_seq #(.DIVIDEND_W(12), .DIVISOR_W(12), .FRAC_W(0)) u_alt (
    .clk(clk), .rst_n(rst_n), .dividend(alt_dividend), .divisor(alt_divisor),
    .val_i(alt_val_i), .rdy_o(alt_rdy_o), .quo(alt_quo), .rem(alt_rem),
    .dbz(alt_dbz), .val_o(alt_val_o), .rdy_i(alt_rdy_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t        e;
    logic [31:0] s;
    if (b == 8'd0) begin
      e.quo = 24'hFFFFFF;
      e.rem = 8'd0;
      e.dbz = 1'b1;
    end else begin
      s     = {8'h00, a, 8'h00};
      e.quo = 24'(s / 32'(b));
      e.rem = 8'(s % 32'(b));
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [23:0] q, input logic [7:0] r, input logic d);
    exp_t e;
    e.quo = q;
    e.rem = r;
    e.dbz = d;
    return e;
  endfunction

  // Random back-pressure source, used only while rand_mode is set
  initial begin
    rdy_rand = 1'b1;
    forever begin
      @(posedge clk);
      #1 rdy_rand = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard: compare each transferred result with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && val_o && rdy_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(val_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("res_quo", 64'(quo), 64'(e.quo));
          check("res_rem", 64'(rem), 64'(e.rem));
          check("res_dbz", 64'(dbz), 64'(e.dbz));
        end
      end
    end
  end

  // Present an operation and push its expectation on the accept edge
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input exp_t e, output time t_acc);
    dividend = a;
    divisor  = b;
    val_i    = 1'b1;
    t_acc    = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rdy_o) begin
        @(posedge clk);
        t_acc = $time;
        exp_q.push_back(e);
        #1;
        val_i    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        return;
      end
    end
    check("accept_timeout", 64'(rdy_o), 64'd1);
    val_i = 1'b0;
  endtask

  // Count edges after the accept until val_o is seen high
  task automatic wait_val(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (val_o) begin
        cycles = k;
        return;
      end
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 3000; k++) begin
      if (exp_q.size() == 0) return;
      @(posedge clk);
      #2;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic alt_op(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] eq, er;
    logic        ed;
    logic        got;
    if (b == 12'd0) begin
      eq = 12'hFFF; er = 12'd0; ed = 1'b1;
    end else begin
      eq = a / b; er = a % b; ed = 1'b0;
    end
    alt_dividend = a;
    alt_divisor  = b;
    alt_val_i    = 1'b1;
    got          = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (alt_rdy_o) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    alt_val_i    = 1'b0;
    alt_dividend = 12'($urandom);
    alt_divisor  = 12'($urandom);
    if (!got) begin
      check("alt_accept_timeout", 64'(alt_rdy_o), 64'd1);
      return;
    end
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (alt_val_o) begin
        got = 1'b1;
        check("alt_quo", 64'(alt_quo), 64'(eq));
        check("alt_rem", 64'(alt_rem), 64'(er));
        check("alt_dbz", 64'(alt_dbz), 64'(ed));
        break;
      end
    end
    if (!got) check("alt_val_timeout", 64'(alt_val_o), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [15:0] a, input logic [7:0] b,
                         input logic [23:0] q, input logic [7:0] r, input logic d);
    vecs[i].a = a;
    vecs[i].b = b;
    vecs[i].e = mk(q, r, d);
  endtask

  initial begin
    time  t1, t2, tdummy;
    int   lat;
    logic saw;
    logic [15:0] ra;
    logic [7:0]  rb;

    set_vec(0, 16'd100,   8'd7,   24'h000E49, 8'd1,   1'b0);
    set_vec(1, 16'd65535, 8'd1,   24'hFFFF00, 8'd0,   1'b0);
    set_vec(2, 16'd1,     8'd255, 24'h000001, 8'd1,   1'b0);
    set_vec(3, 16'd5,     8'd0,   24'hFFFFFF, 8'd0,   1'b1);
    set_vec(4, 16'd200,   8'd3,   24'h0042AA, 8'd2,   1'b0);
    set_vec(5, 16'd1000,  8'd10,  24'h006400, 8'd0,   1'b0);
    set_vec(6, 16'd65535, 8'd255, 24'h010100, 8'd0,   1'b0);
    set_vec(7, 16'd12345, 8'd200, 24'h003DB9, 8'd120, 1'b0);
    set_vec(8, 16'd0,     8'd9,   24'h000000, 8'd0,   1'b0);
    set_vec(9, 16'd7,     8'd7,   24'h000100, 8'd0,   1'b0);

    rst_n        = 1'b0;
    val_i        = 1'b0;
    dividend     = '0;
    divisor      = '0;
    rdy_fix      = 1'b1;
    rand_mode    = 1'b0;
    alt_val_i    = 1'b0;
    alt_dividend = '0;
    alt_divisor  = '0;
    alt_rdy_i    = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy_o", 64'(rdy_o), 64'd0);
    check("rst_val_o", 64'(val_o), 64'd0);
    check("rst_quo",   64'(quo),   64'd0);
    check("rst_rem",   64'(rem),   64'd0);
    check("rst_dbz",   64'(dbz),   64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_rst", 64'(rdy_o), 64'd1);

    // Latency: normal divide and divide by zero
    do_op(16'd100, 8'd7, vecs[0].e, tdummy);
    wait_val(lat);
    check("latency_normal", 64'(lat), 64'd24);
    wait_drain();
    do_op(16'd5, 8'd0, vecs[3].e, tdummy);
    wait_val(lat);
    check("latency_dbz", 64'(lat), 64'd1);
    wait_drain();
    do_op(16'd100, 8'd7, vecs[0].e, tdummy);
    wait_drain();

    // Back-to-back throughput with rdy_i held high
    do_op(vecs[1].a, vecs[1].b, vecs[1].e, t1);
    do_op(vecs[2].a, vecs[2].b, vecs[2].e, t2);
    check("throughput_cycles", 64'((t2 - t1) / 10), 64'd26);
    wait_drain();

    // Vector table
    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].e, tdummy);
    wait_drain();

    // Back-pressure: hold the result, and ignore val_i while it is held
    rdy_fix = 1'b0;
    do_op(16'd1000, 8'd10, vecs[5].e, tdummy);
    wait_val(lat);
    check("latency_bp", 64'(lat), 64'd24);
    for (int i = 0; i < 10; i++) begin
      check("bp_val_o", 64'(val_o), 64'd1);
      check("bp_rdy_o", 64'(rdy_o), 64'd0);
      check("bp_quo",   64'(quo),   64'h006400);
      check("bp_rem",   64'(rem),   64'd0);
      if (i == 2) begin
        dividend = 16'd3;
        divisor  = 8'd1;
        val_i    = 1'b1;
      end
      if (i == 6) val_i = 1'b0;
      @(posedge clk);
      #1;
    end
    rdy_fix = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_val_o", 64'(val_o), 64'd0);
    check("bp_release_rdy_o", 64'(rdy_o), 64'd1);
    @(posedge clk);
    #1;
    check("bp_no_accept", 64'(rdy_o), 64'd1);
    wait_drain();

    // Reset during BUSY, applied at iteration 10
    do_op(16'd60000, 8'd13, model(16'd60000, 8'd13), tdummy);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_val_o", 64'(val_o), 64'd0);
    check("midrst_rdy_o", 64'(rdy_o), 64'd0);
    check("midrst_quo",   64'(quo),   64'd0);
    check("midrst_rem",   64'(rem),   64'd0);
    check("midrst_dbz",   64'(dbz),   64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rdy_after", 64'(rdy_o), 64'd1);
    saw = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (val_o) saw = 1'b1;
    end
    check("midrst_no_val_o", 64'(saw), 64'd0);
    do_op(16'd200, 8'd3, vecs[4].e, tdummy);
    wait_val(lat);
    check("latency_after_rst", 64'(lat), 64'd24);
    wait_drain();

    // Random sweep with random back-pressure and idle gaps
    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_op(ra, rb, model(ra, rb), tdummy);
    end
    wait_drain();
    rand_mode = 1'b0;
    @(posedge clk);
    #1;

    // Alternate parameter set: 12-bit / 12-bit, no fractional bits
    alt_op(12'd4095, 12'd1);
    alt_op(12'd4095, 12'd4095);
    alt_op(12'd5,    12'd0);
    alt_op(12'd100,  12'd7);
    for (int n = 0; n < 60; n++) alt_op(12'($urandom), 12'($urandom_range(0, 4095)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
